// File: rtl/periph_pkg.sv
// rtl/periph_pkg.sv - register offsets, TCON bit indices and hex glyph table
// Shared by the peripheral top and the seven-segment scanner.
package periph_pkg;

  localparam logic [31:0] OFF_TH      = 32'h00;
  localparam logic [31:0] OFF_TL      = 32'h04;
  localparam logic [31:0] OFF_TCON    = 32'h08;
  localparam logic [31:0] OFF_LEDS    = 32'h0C;
  localparam logic [31:0] OFF_DIGITS  = 32'h10;
  localparam logic [31:0] OFF_DEN     = 32'h14;
  localparam logic [31:0] OFF_SYSTICK = 32'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // Active-low {dp,g,f,e,d,c,b,a}, dp held off; entry 0 is the rightmost.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/mmio_peripheral_if.sv
// rtl/mmio_peripheral_if.sv - CPU data bus as seen by memory-mapped peripherals
// Read_data is combinational from the slave.
interface mmio_peripheral_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data
  );
endinterface

// File: rtl/mmio_peripheral_seg_scan.sv
// rtl/mmio_peripheral_seg_scan.sv - multiplexed seven-segment scanner
// Divider, digit index, DEN blanking, hex decode, registered ano/seg.
module seg_scan
  import periph_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   den,
  output logic [NUM_DIGITS-1:0]   ano,
  output logic [7:0]              seg
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] ano_q, ano_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tc;

  always_comb begin
    tc    = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d = tc ? '0 : div_q + DIV_W'(1);
    idx_d = idx_q;
    if (tc) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    // Outputs trail the index by one cycle so they change right after terminal count.
    ano_d = '1;
    if (den[idx_q]) begin
      ano_d = ~(NUM_DIGITS'(1) << idx_q);
    end
    seg_d = SEG_LUT[digits[{idx_q, 2'b00} +: 4]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      ano_q <= '1;
      seg_q <= 8'hFF;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      ano_q <= ano_d;
      seg_q <= seg_d;
    end
  end

  assign ano = ano_q;
  assign seg = seg_q;

endmodule

// File: rtl/mmio_peripheral.sv
// rtl/mmio_peripheral.sv - MMIO peripheral: decode, LEDs, digits, timer, SYSTICK
// Timer registers and irq exist only when PERIPH_TIMER_EN is defined.
module mmio_peripheral
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          NUM_DIGITS = 4,
  parameter int          LED_WIDTH  = 8,
  parameter int          SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmio_peripheral_if.slave      bus,
  output logic [LED_WIDTH-1:0]  leds,
  output logic [NUM_DIGITS-1:0] ano,
  output logic [7:0]            seg,
  output logic                  irq
);

  logic [31:0] off;
  logic        wr_leds, wr_digits, wr_den;

  logic [LED_WIDTH-1:0]    leds_q, leds_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   den_q, den_d;
  logic [31:0]             systick_q, systick_d;
  logic [31:0]             th_rd, tl_rd, tcon_rd;
  logic [31:0]             rdata;

  // Offset subtraction keeps the full 32-bit compare against BASE_ADDR.
  assign off       = bus.Address - BASE_ADDR;
  assign wr_leds   = bus.MemWrite && (off == OFF_LEDS);
  assign wr_digits = bus.MemWrite && (off == OFF_DIGITS);
  assign wr_den    = bus.MemWrite && (off == OFF_DEN);

  always_comb begin
    leds_d    = leds_q;
    digits_d  = digits_q;
    den_d     = den_q;
    systick_d = systick_q + 32'd1;
    if (wr_leds)   leds_d   = bus.Write_data[LED_WIDTH-1:0];
    if (wr_digits) digits_d = bus.Write_data[4*NUM_DIGITS-1:0];
    if (wr_den)    den_d    = bus.Write_data[NUM_DIGITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q    <= '0;
      digits_q  <= '0;
      den_q     <= '1;
      systick_q <= '0;
    end else begin
      leds_q    <= leds_d;
      digits_q  <= digits_d;
      den_q     <= den_d;
      systick_q <= systick_d;
    end
  end

`ifdef PERIPH_TIMER_EN
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic        en_q, en_d, ie_q, ie_d, st_q, st_d;
  logic        wr_th, wr_tl, wr_tcon, ovf;

  assign wr_th   = bus.MemWrite && (off == OFF_TH);
  assign wr_tl   = bus.MemWrite && (off == OFF_TL);
  assign wr_tcon = bus.MemWrite && (off == OFF_TCON);

  // Precedence: CPU write to TL beats reload/increment; overflow set beats W1C.
  always_comb begin
    ovf  = en_q && (tl_q == 32'hFFFF_FFFF);
    th_d = wr_th ? bus.Write_data : th_q;
    tl_d = ovf ? th_q : (en_q ? tl_q + 32'd1 : tl_q);
    if (wr_tl) tl_d = bus.Write_data;
    en_d = wr_tcon ? bus.Write_data[TCON_EN] : en_q;
    ie_d = wr_tcon ? bus.Write_data[TCON_IE] : ie_q;
    st_d = st_q;
    if (wr_tcon && bus.Write_data[TCON_ST]) st_d = 1'b0;
    if (ovf) st_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q <= '0;
      tl_q <= '0;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
      en_q <= en_d;
      ie_q <= ie_d;
      st_q <= st_d;
    end
  end

  always_comb begin
    tcon_rd          = '0;
    tcon_rd[TCON_EN] = en_q;
    tcon_rd[TCON_IE] = ie_q;
    tcon_rd[TCON_ST] = st_q;
  end

  assign th_rd = th_q;
  assign tl_rd = tl_q;
  assign irq   = ie_q & st_q;
`else
  logic unused_wdata;

  assign unused_wdata = ^bus.Write_data;
  assign th_rd        = '0;
  assign tl_rd        = '0;
  assign tcon_rd      = '0;
  assign irq          = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      case (off)
        OFF_TH:      rdata = th_rd;
        OFF_TL:      rdata = tl_rd;
        OFF_TCON:    rdata = tcon_rd;
        OFF_LEDS:    rdata = 32'(leds_q);
        OFF_DIGITS:  rdata = 32'(digits_q);
        OFF_DEN:     rdata = 32'(den_q);
        OFF_SYSTICK: rdata = systick_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.Read_data = rdata;
  assign leds          = leds_q;

  seg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_seg_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .digits (digits_q),
    .den    (den_q),
    .ano    (ano),
    .seg    (seg)
  );

endmodule

// File: tb/tb_mmio_peripheral.sv
// tb/tb_mmio_peripheral.sv - randomized self-checking bench for mmio_peripheral
// Timer expectations follow PERIPH_TIMER_EN.
module tb_mmio_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int N  = 4;
  localparam int LW = 8;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmio_peripheral_if bus ();
  logic [LW-1:0] leds;
  logic [N-1:0]  ano;
  logic [7:0]    seg;
  logic          irq;

  mmio_peripheral #(
    .BASE_ADDR  (BASE),
    .NUM_DIGITS (N),
    .LED_WIDTH  (LW),
    .SCAN_DIV   (SD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .leds  (leds),
    .ano   (ano),
    .seg   (seg),
    .irq   (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: registers as the CPU sees them plus edges since reset.
  logic [31:0] m_th, m_tl, m_ticks;
  logic        m_en, m_ie, m_st;
  logic [LW-1:0]  m_leds;
  logic [15:0]    m_digits;
  logic [N-1:0]   m_den;
  logic [N-1:0]   exp_ano;
  logic [7:0]     exp_seg;

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_ticks = 0;
    m_en = 0; m_ie = 0; m_st = 0;
    m_leds = 0; m_digits = 0; m_den = '1;
    exp_ano = '1; exp_seg = 8'hFF;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    case (o)
`ifdef PERIPH_TIMER_EN
      32'h00: return m_th;
      32'h04: return m_tl;
      32'h08: return {29'd0, m_st, m_ie, m_en};
`endif
      32'h0C: return {24'd0, m_leds};
      32'h10: return {16'd0, m_digits};
      32'h14: return {28'd0, m_den};
      32'h18: return m_ticks;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] o;
    int idx;
    logic ovf;
    o   = a - BASE;
    idx = (m_ticks / SD) % N;
    exp_ano = m_den[idx] ? ~(4'b0001 << idx) : 4'b1111;
    exp_seg = glyph[m_digits[idx*4 +: 4]];
`ifdef PERIPH_TIMER_EN
    ovf = m_en && (m_tl == 32'hFFFF_FFFF);
    if (ovf) m_tl = m_th;
    else if (m_en) m_tl = m_tl + 1;
    if (wr && o == 32'h04) m_tl = d;
    if (wr && o == 32'h00) m_th = d;
    if (wr && o == 32'h08) begin
      m_en = d[0];
      m_ie = d[1];
      if (d[2]) m_st = 0;
    end
    if (ovf) m_st = 1;
`else
    ovf = 0;
`endif
    if (wr && o == 32'h0C) m_leds = d[LW-1:0];
    if (wr && o == 32'h10) m_digits = d[15:0];
    if (wr && o == 32'h14) m_den = d[N-1:0];
    m_ticks = m_ticks + 1;
  endtask

  // Called at a negedge; drives one bus cycle and checks read data and outputs.
  task automatic tick(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.Address    = a;
    bus.Write_data = d;
    #1;
    check("read_data", bus.Read_data, rd ? model_read(a) : 32'd0);
    @(posedge clk);
    model_step(wr, a, d);
    #1;
    check("leds", 32'(leds), 32'(m_leds));
    check("ano", 32'(ano), 32'(exp_ano));
    check("seg", 32'(seg), 32'(exp_seg));
    check("irq", 32'(irq), 32'(m_ie & m_st));
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_leds"}, 32'(leds), 32'd0);
    check({tag, "_ano"}, 32'(ano), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'hFF);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    bus.MemRead = 0; bus.MemWrite = 0; bus.Address = 0; bus.Write_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int o = 0; o <= 8'h1C; o += 4) tick(1, 0, BASE + 32'(o), 0);

    tick(0, 1, BASE + 32'h0C, 32'h1A5);
    check("leds_a5", 32'(leds), 32'hA5);
    tick(1, 0, BASE + 32'h0C, 0);
    tick(1, 0, BASE + 32'h1C, 0);
    tick(0, 0, BASE + 32'h0C, 0);

    tick(0, 1, BASE + 32'h10, 32'h0000_3A1F);
    tick(0, 1, BASE + 32'h14, 32'hB);
    repeat (24) tick(0, 0, 0, 0);

    tick(0, 1, BASE + 32'h00, 32'hFFFF_FFFD);
    tick(0, 1, BASE + 32'h04, 32'hFFFF_FFFE);
    tick(0, 1, BASE + 32'h08, 32'h3);
    repeat (4) tick(1, 0, BASE + 32'h04, 0);
    tick(1, 0, BASE + 32'h08, 0);
    tick(0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
    tick(0, 1, BASE + 32'h08, 32'h7);
    tick(1, 0, BASE + 32'h08, 0);
    tick(0, 1, BASE + 32'h08, 32'h7);
    tick(1, 0, BASE + 32'h08, 0);

    repeat (6) tick(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    tick(0, 1, BASE + 32'h04, 32'd5);
    tick(1, 0, BASE + 32'h04, 0);

    repeat (400) begin
      logic [31:0] a, d;
      logic rd, wr;
      a = BASE + 32'($urandom_range(0, 8) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) a = a ^ 32'h0100_0000;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      tick(rd, wr, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_peripheral.md
# mmio_peripheral

Parametrised memory-mapped peripheral block on the CPU data bus, decoded from a configurable base address. It provides an LED register, an N-digit multiplexed seven-segment display with hex decode and per-digit blanking, a reloadable 32-bit timer with interrupt, and a free-running cycle counter. It sits beside data memory, and the CPU reaches it through the same MemRead/MemWrite/Address/Write_data/Read_data bus.

## Interface
- BASE_ADDR, 32'h4000_0000, byte address of register offset 0x00
- NUM_DIGITS, 4, seven-segment digits, legal range 1..8
- LED_WIDTH, 8, LED count, legal range 1..32
- SCAN_DIV, 50000, clock cycles per digit slot, must be ≥ 2
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- MemRead  in  1  read strobe
- MemWrite  in  1  write strobe
- Address  in  32  byte address, full 32-bit compare
- Write_data  in  32  write data
- Read_data  out  32  read data, combinational
- leds  out  LED_WIDTH  LED drive, active-high
- ano  out  NUM_DIGITS  digit anodes, active-low, one-hot or all-ones
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- irq  out  1  timer interrupt, level, active-high

## Operation
- Register map, as offset from BASE_ADDR:
  - 0x00 TH: timer reload value, R/W
  - 0x04 TL: timer count, R/W
  - 0x08 TCON: [0] enable, [1] irq enable, [2] status. Bits [1:0] are R/W; bit [2] is W1C.
  - 0x0C LEDS: [LED_WIDTH-1:0], R/W
  - 0x10 DIGITS: 4 bits per digit, digit k in [4k+3:4k], R/W
  - 0x14 DEN: per-digit enable mask [NUM_DIGITS-1:0], R/W
  - 0x18 SYSTICK: cycle counter, read-only, writes ignored
- Reads:
  - Read_data = register value, zero-extended, when MemRead is high and the address hits.
  - Read_data = 0 when MemRead is low or the address is unmapped.
  - Unwritable bits read 0.
- Writes:
  - Unmapped writes are ignored.
  - Writes outside the valid width are truncated.
- Timer:
  - While TCON[0]=1, TL increments by 1 every cycle.
  - When TL==32'hFFFF_FFFF and enabled, the next cycle loads TL<=TH and sets TCON[2].
  - irq = TCON[1] & TCON[2].
- Scanner:
  - A divider counts 0..SCAN_DIV-1. On terminal count, the digit index advances and wraps from NUM_DIGITS-1 to 0.
  - ano = ~(1<<idx) if DEN[idx]; otherwise all-ones.
  - seg = hex decode of DIGITS nibble idx (0–F glyphs), with dp always off (1).
- SYSTICK increments every cycle and wraps to 0.

## Timing
- Reset values:
  - TH, TL, TCON, LEDS, DIGITS, SYSTICK, divider and index: 0
  - DEN: all-ones
  - leds: 0
  - ano: all-ones
  - seg: 8'hFF
  - irq: 0
- Read latency is 0 cycles (combinational). Write latency is 1 cycle: the value is visible from the next posedge.
- ano/seg are registered. They show digit 0 from the first posedge after reset release and change exactly one cycle after divider terminal count.
- Simultaneous events:
  - CPU write to TL in the same cycle as an increment or reload: the write wins.
  - Overflow set and W1C clear of TCON[2] in the same cycle: the set wins, so no interrupt is lost.
  - Write to TH in the reload cycle: the reload uses the old TH.
  - Writing TCON[0]=0 in the overflow cycle: the reload still occurs.
- If rst_n asserts mid-scan or mid-count, all state returns to its reset value asynchronously with no glitch hold.

## Configuration
- PERIPH_TIMER_EN defined: TH/TL/TCON and irq are implemented as above.
- PERIPH_TIMER_EN undefined: no timer flops are synthesised. Offsets 0x00–0x08 read 0, writes to them are ignored, and irq is tied to 0. All other registers are unaffected.

## Structure
- Shared package `periph_pkg` holds the register offset constants (OFF_TH … OFF_SYSTICK), the TCON bit indices and the 16-entry hex-to-segment constant table.
- Sub-module `seg_scan` (divider, digit index, DEN masking, decode, output registers) is instantiated once. The top-level holds decode, registers, timer and SYSTICK.

## Test plan
- Reset, then read every offset → TH/TL/TCON/LEDS/DIGITS/SYSTICK read 0, DEN reads 0xF, ano=4'b1111, seg=8'hFF, irq=0.
- Write LEDS=0x1A5, then read back → leds=8'hA5 one cycle later, and the read returns 0xA5. A read of BASE+0x1C returns 0.
- Set DIGITS=0x0000_3A1F and DEN=4'b1011 with SCAN_DIV=4 → slots cycle through ano 1110/seg F, 1101/seg 1, 1111 (blanked), 0111/seg 3, then wrap to digit 0.
- Set TH=0xFFFF_FFFD, TL=0xFFFF_FFFE and TCON=3 → TL reads FE, FF, then FD. TCON[2]=1 and irq=1 after the reload, and the counting continues.
- While irq=1, write TCON=0x7 in the same cycle as the next overflow → TCON[2] stays 1 (set wins). A later write of 0x7 clears it and drops irq.
- Assert rst_n low mid-scan with the timer running → all outputs reach their reset values before the next posedge. With PERIPH_TIMER_EN undefined, a write of TL=5 reads back 0 and irq stays 0.
